// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator feeder.
package accum_pkg;
  localparam int unsigned DEFAULT_ACCUM_WIDTH = 48;
  localparam int unsigned ERR_CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESULT,
    CLEAR
  } feeder_state_t;
endpackage

// File: rtl/accum_fifo.sv
// Synchronous operand FIFO; writes when not full, reads when not empty.
module accum_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/accum_feeder.sv
// Sequences one Accum session per buffered operand and returns the result,
// re-arming Accum with a one-cycle clear and guarding with a timeout.
module accum_feeder
  import accum_pkg::*;
#(
  parameter int unsigned ACCUM_WIDTH = DEFAULT_ACCUM_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACCUM_WIDTH-1:0] in_data,
  output logic                   acc_en,
  output logic [ACCUM_WIDTH-1:0] acc_add,
  output logic                   acc_rst_l,
  input  logic [ACCUM_WIDTH-1:0] acc_accum,
  input  logic                   acc_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACCUM_WIDTH-1:0] res_data,
  output logic                   res_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);
  localparam int unsigned TO_W = 8;

  feeder_state_t          state_q, state_d;
  logic [ACCUM_WIDTH-1:0] op_q, op_d;
  logic [TO_W-1:0]        cnt_q, cnt_d;
  logic [ACCUM_WIDTH-1:0] res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
  logic                   res_valid_q, res_valid_d;
  logic                   acc_en_q, acc_en_d;
  logic                   acc_rst_l_q, acc_rst_l_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   fifo_pop_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ACCUM_WIDTH-1:0] fifo_rdata;

  accum_fifo #(
    .WIDTH (ACCUM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_l (reset_l),
    .push    (in_valid),
    .wdata   (in_data),
    .pop     (fifo_pop_c),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign acc_en    = acc_en_q;
  assign acc_add   = op_q;
  assign acc_rst_l = acc_rst_l_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    err_cnt_d  = err_cnt_q;
    fifo_pop_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && acc_rst_l_q) begin
          fifo_pop_c = 1'b1;
          op_d       = fifo_rdata;
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + TO_W'(1);
        // A done arriving on the timeout cycle still counts as success.
        if (acc_done) begin
          res_data_d = acc_accum;
          res_err_d  = 1'b0;
          state_d    = RESULT;
        end else if (cnt_d == TO_W'(TIMEOUT)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          state_d    = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered strobes follow the state being entered, so they stay glitch-free.
    acc_en_d    = (state_d == ISSUE);
    res_valid_d = (state_d == RESULT);
    acc_rst_l_d = (state_d != CLEAR);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_rst_l_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      acc_en_q    <= acc_en_d;
      acc_rst_l_q <= acc_rst_l_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule
